// File: rtl/window_gen_3x3.sv
// Streams an image out of a synchronous ROM in raster order and turns it into
// 3x3 pixel windows, with valid/ready backpressure and a one-entry skid buffer.
module window_gen_3x3 #(
    parameter int ROWS = 35,
    parameter int COLS = 368,
    parameter int PW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [5:0]      rom_row,
    output logic [8:0]      rom_col,
    input  logic [11:0]     rom_data,
    output logic [9*PW-1:0] win,
    output logic [5:0]      win_row,
    output logic [8:0]      win_col,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    localparam logic [8:0] LAST_COL = 9'(COLS - 1);
    localparam logic [5:0] END_ROW  = 6'(ROWS - 2);
    localparam logic [8:0] END_COL  = 9'(COLS - 2);

    state_t        state;
    logic          stall;
    logic          xfer;
    logic          issue;
    logic          vld_p0;
    logic [5:0]    row_p0;
    logic [8:0]    col_p0;
    logic          skid_full;
    logic [PW-1:0] skid_pix;
    logic [5:0]    skid_row;
    logic [8:0]    skid_col;
    logic          take;
    logic [PW-1:0] pix;
    logic [5:0]    pix_row;
    logic [8:0]    pix_col;
    logic [PW-1:0] up2;
    logic [PW-1:0] up1;
    logic [PW-1:0] lb0 [COLS];
    logic [PW-1:0] lb1 [COLS];
    logic          unused_rom_bits;

    assign stall = win_valid && !win_ready;
    assign xfer  = win_valid && win_ready;
    assign issue = (state == FETCH) && !stall;
    assign unused_rom_bits = ^rom_data[11:PW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rom_row <= '0;
            rom_col <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        rom_row <= '0;
                        rom_col <= '0;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (rom_col == LAST_COL) begin
                            if (rom_row == LAST_ROW) begin
                                state <= DRAIN;
                            end else begin
                                rom_row <= rom_row + 6'd1;
                                rom_col <= '0;
                            end
                        end else begin
                            rom_col <= rom_col + 9'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && win_row == END_ROW && win_col == END_COL) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- p0: address issued, ROM word arrives next cycle ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            vld_p0 <= issue;
            if (stall && vld_p0) begin
                skid_full <= 1'b1;
            end else if (!stall) begin
                skid_full <= 1'b0;
            end
        end
    end

    // Skid is drained before any fresh ROM word; the two never coincide since no address is issued while stalled.
    always_comb begin
        pix     = rom_data[PW-1:0];
        pix_row = row_p0;
        pix_col = col_p0;
        if (skid_full) begin
            pix     = skid_pix;
            pix_row = skid_row;
            pix_col = skid_col;
        end
    end

    assign take = !stall && (skid_full || vld_p0);
    assign up2  = lb0[pix_col];
    assign up1  = lb1[pix_col];

    always_ff @(posedge clk) begin
        if (issue) begin
            row_p0 <= rom_row;
            col_p0 <= rom_col;
        end
        if (stall && vld_p0) begin
            skid_pix <= rom_data[PW-1:0];
            skid_row <= row_p0;
            skid_col <= col_p0;
        end
        if (take) begin
            lb0[pix_col] <= up1;
            lb1[pix_col] <= pix;
        end
    end

    // ---- p1: pixel absorbed, window shifts one column left ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= '0;
            win_row   <= '0;
            win_col   <= '0;
            win_valid <= 1'b0;
        end else begin
            if (take) begin
                for (int k = 0; k < 3; k++) begin
                    win[PW*(3*k)   +: PW] <= win[PW*(3*k+1) +: PW];
                    win[PW*(3*k+1) +: PW] <= win[PW*(3*k+2) +: PW];
                end
                win[PW*2 +: PW] <= up2;
                win[PW*5 +: PW] <= up1;
                win[PW*8 +: PW] <= pix;
            end
            if (take && pix_row >= 6'd2 && pix_col >= 9'd2) begin
                win_valid <= 1'b1;
                win_row   <= pix_row - 6'd1;
                win_col   <= pix_col - 9'd1;
            end else if (xfer) begin
                win_valid <= 1'b0;
            end
        end
    end
endmodule
